sp1_ram_mst: RTL and testbench
==============================

SP1_RAM_MST -- requirements
Module: sp1_ram_mst

Interface
REQ-001 Parameter AW, default 6, RAM address width in bits.
REQ-002 Parameter DW, default 32, RAM data width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at posedge.
REQ-007 cmd_op  input  2  00 READ, 01 WRITE, 10 FILL, 11 reserved.
REQ-008 cmd_adr  input  AW  burst start address.
REQ-009 cmd_len  input  AW  burst length minus one (1..2^AW words).
REQ-010 cmd_data  input  DW  FILL pattern.
REQ-011 wr_valid / wr_ready  input / output  1 each  WRITE data stream handshake.
REQ-012 wr_data  input  DW  WRITE data word.
REQ-013 rd_valid / rd_ready  output / input  1 each  READ data stream handshake.
REQ-014 rd_data  output  DW  READ data word.
REQ-015 done  output  1  one-cycle pulse, command complete.
REQ-016 err  output  1  one-cycle pulse with done, reserved op.
REQ-017 ram_cs, ram_we  output  1 each  RAM strobe, write enable.
REQ-018 ram_adr  output  AW  RAM address; ram_din  output  DW  RAM write data.
REQ-019 ram_dout  input  DW  RAM read data, valid the cycle after a cs&~we access.

Function
REQ-020 States IDLE, READ, WRITE, FILL, DRAIN, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on accept, latch adr/len/data, remaining=len+1, go to READ/WRITE/FILL; op 11 goes to DONE with err.
REQ-022 Address SHALL increment by 1 per access, wrapping modulo 2^AW (e.g. 3F -> 00).
REQ-023 Each RAM access SHALL be one cycle with ram_cs=1; ram_cs=0 cycles drive ram_we=0.
REQ-024 WRITE: wr_ready=1 in WRITE; each wr_valid&wr_ready cycle SHALL drive cs=1, we=1, adr, din=wr_data in that same cycle; no access when wr_valid=0.
REQ-025 FILL: cs=1, we=1, din=latched cmd_data every cycle, one word per cycle, no stalls.
REQ-026 READ: 2-entry output FIFO; issue read (cs=1, we=0) only when fifo_count+inflight<2; capture ram_dout into FIFO the cycle after issue.
REQ-027 READ with rd_ready held 1 SHALL sustain one word per cycle after first-word latency of 2 cycles from accept.
REQ-028 rd_valid = FIFO non-empty; rd_data = FIFO head; rd_data SHALL hold stable while rd_valid&~rd_ready.
REQ-029 After last read issued go to DRAIN; leave DRAIN when FIFO empty and nothing inflight.
REQ-030 WRITE/FILL: after last access go to DONE next cycle.
REQ-031 DONE: assert done one cycle (err too for op 11), return to IDLE; next command acceptable the cycle after.
REQ-032 Words delivered in address order; count exactly len+1 per burst; len=all-ones means 2^AW words, wrapping back to start.
REQ-033 No RAM write SHALL occur during READ/DRAIN; no RAM read during WRITE/FILL.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, clear FIFO, inflight, counters.
REQ-035 During reset: cmd_ready=0, wr_ready=0, rd_valid=0, done=0, err=0, ram_cs=0, ram_we=0, ram_adr=0, ram_din=0, rd_data=0.
REQ-036 cmd_ready SHALL rise the first posedge after rst deasserts.
REQ-037 Reset mid-burst SHALL abort with no done pulse and no further RAM access.

Verification
REQ-038 WRITE adr=05 len=0 data 12345678 -> one cycle cs=1 we=1 adr=05 din=12345678; done 1 cycle later.
REQ-039 READ adr=05 len=0 after REQ-038 -> rd_data=12345678, rd_valid 2 cycles after accept; done after pop.
REQ-040 FILL adr=3E len=3 data A5A5A5A5 -> writes to 3E,3F,00,01 on 4 consecutive cycles; READ back returns A5A5A5A5 x4.
REQ-041 READ len=7, rd_ready toggled 1/0 -> 8 words in order, none lost/duplicated, fifo_count+inflight never >2.
REQ-042 rst low during 8-word WRITE after 3 words -> outputs zero immediately, no done; post-reset READ shows only 3 words written.
REQ-043 cmd_op=11 -> no RAM access; done=1 and err=1 for one cycle; cmd_ready back next cycle.

Source files
------------

// File: rtl/sp1_ram_mst.sv
// rtl/sp1_ram_mst.sv - single-port RAM burst master: READ / WRITE / FILL bursts with a 2-deep read FIFO
module sp1_ram_mst #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_adr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          alive_q;
  logic [AW-1:0] adr_q;
  logic [AW:0]   remain_q;
  logic [DW-1:0] fill_q;
  logic          err_q;
  logic          inflight_q;
  logic [DW-1:0] fifo0_q, fifo1_q;
  logic          wptr_q, rptr_q;
  logic [1:0]    count_q;

  logic          pop;
  logic          last;
  logic          accept;
  logic [1:0]    occ;

  assign rd_valid = (count_q != 2'd0);
  assign rd_data  = rptr_q ? fifo1_q : fifo0_q;
  assign pop      = rd_valid & rd_ready;
  assign last     = (remain_q == (AW+1)'(1));
  assign accept   = cmd_valid & cmd_ready;
  // Occupancy after this cycle's pop; lets a read issue alongside a pop for full throughput.
  assign occ      = count_q - {1'b0, pop} + {1'b0, inflight_q};

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_adr   = '0;
    ram_din   = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = alive_q;
        if (cmd_valid && alive_q) begin
          case (cmd_op)
            2'b00:   state_d = S_READ;
            2'b01:   state_d = S_WRITE;
            2'b10:   state_d = S_FILL;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_READ: begin
        if (occ < 2'd2) begin
          ram_cs  = 1'b1;
          ram_adr = adr_q;
          if (last) state_d = S_DRAIN;
        end
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_cs  = 1'b1;
          ram_we  = 1'b1;
          ram_adr = adr_q;
          ram_din = wr_data;
          if (last) state_d = S_DONE;
        end
      end
      S_FILL: begin
        ram_cs  = 1'b1;
        ram_we  = 1'b1;
        ram_adr = adr_q;
        ram_din = fill_q;
        if (last) state_d = S_DONE;
      end
      S_DRAIN: begin
        if (count_q == 2'd0 && !inflight_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      alive_q    <= 1'b0;
      adr_q      <= '0;
      remain_q   <= '0;
      fill_q     <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) begin
        adr_q    <= cmd_adr;
        remain_q <= {1'b0, cmd_len} + (AW+1)'(1);
        fill_q   <= cmd_data;
        err_q    <= (cmd_op == 2'b11);
      end else if (ram_cs) begin
        adr_q    <= adr_q + AW'(1);
        remain_q <= remain_q - (AW+1)'(1);
      end
      // RAM read data is valid exactly one cycle after the strobe.
      inflight_q <= ram_cs & ~ram_we;
      if (inflight_q) begin
        if (wptr_q) fifo1_q <= ram_dout;
        else        fifo0_q <= ram_dout;
        wptr_q <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_sp1_ram_mst.sv
// tb/tb_sp1_ram_mst.sv - self-checking bench for sp1_ram_mst with RAM model and read scoreboard
module tb_sp1_ram_mst;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RESV  = 2'b11;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_adr;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic        ram_cs;
  logic        ram_we;
  logic [5:0]  ram_adr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  sp1_ram_mst #(.AW(6), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_adr(ram_adr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (ram_cs) begin
      if (ram_we) mem[ram_adr] <= ram_din;
      else        ram_dout     <= mem[ram_adr];
    end
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] exp_q [$];
  logic [1:0]  cur_op;
  int acc_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  int rd_out = 0;
  int rd_max = 0;

  always @(negedge clk) begin
    #3;
    if (!rst) begin
      rd_out = 0;
    end else begin
      if (ram_cs) acc_cnt++;
      if (done) done_cnt++;
      if (ram_cs && ram_we && cur_op == OP_READ) viol++;
      if (ram_cs && !ram_we && cur_op != OP_READ) viol++;
      rd_out = rd_out + int'(ram_cs && !ram_we) - int'(rd_valid && rd_ready);
      if (rd_out > rd_max) rd_max = rd_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  adr;
    logic [5:0]  len;
    logic [31:0] data;
    int          mode;
    logic        exp_err;
    int          exp_n;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic pop_chk();
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL rd_extra: got %h expected no word", rd_data);
    end else begin
      e = exp_q.pop_front();
      if (rd_data !== e) begin
        failures++;
        $display("FAIL rd_data: got %h expected %h", rd_data, e);
      end
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] adr,
                          input logic [5:0] len, input logic [31:0] data);
    int k;
    cur_op    = op;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_adr   = adr;
    cmd_len   = len;
    cmd_data  = data;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_seen", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int idx, popped, acc0, k;
    logic seen;
    logic [5:0] a;
    idx = 0; popped = 0; seen = 1'b0;
    if (v.op == OP_FILL)
      for (int i = 0; i <= int'(v.len); i++) begin
        a = v.adr + 6'(i);
        ref_mem[a] = v.data;
      end
    if (v.op == OP_READ)
      for (int i = 0; i <= int'(v.len); i++) begin
        a = v.adr + 6'(i);
        exp_q.push_back(ref_mem[a]);
      end
    acc0 = acc_cnt;
    send_cmd(v.op, v.adr, v.len, v.data);
    for (k = 0; k < 600 && !seen; k++) begin
      if (v.op == OP_WRITE) begin
        if (idx <= int'(v.len)) begin
          wr_valid = pick(v.mode, k);
          wr_data  = v.data + 32'(idx);
        end else begin
          wr_valid = 1'b0;
        end
        if (wr_valid && wr_ready) begin
          a = v.adr + 6'(idx);
          ref_mem[a] = wr_data;
          idx++;
        end
      end
      if (v.op == OP_READ) begin
        rd_ready = pick(v.mode, k);
        if (rd_valid && rd_ready) begin
          pop_chk();
          popped++;
        end
      end
      if (done) begin
        seen = 1'b1;
        chk("err_flag", err, v.exp_err);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("done_seen", seen, 1);
    chk("done_one_cycle", done, 0);
    chk("cmd_ready_after_done", cmd_ready, 1);
    if (v.op == OP_WRITE) chk("write_words", idx, v.exp_n);
    if (v.op == OP_READ)  chk("read_words", popped, v.exp_n);
    chk("ram_accesses", acc_cnt - acc0, v.exp_n);
  endtask

  initial begin
    int k, acc0, done0, idx;
    logic [5:0] a;
    vecs[0] = '{OP_READ,  6'h3E, 6'd3,  32'h0,        0, 1'b0, 4};
    vecs[1] = '{OP_WRITE, 6'h10, 6'd7,  32'hC0DE0000, 1, 1'b0, 8};
    vecs[2] = '{OP_READ,  6'h10, 6'd7,  32'h0,        1, 1'b0, 8};
    vecs[3] = '{OP_RESV,  6'h00, 6'd0,  32'h0,        0, 1'b1, 0};
    vecs[4] = '{OP_WRITE, 6'h3C, 6'd5,  32'h0BAD0000, 2, 1'b0, 6};
    vecs[5] = '{OP_READ,  6'h3A, 6'd9,  32'h0,        2, 1'b0, 10};
    vecs[6] = '{OP_FILL,  6'h20, 6'h3F, 32'h5A5A5A5A, 0, 1'b0, 64};
    vecs[7] = '{OP_READ,  6'h21, 6'h3F, 32'h0,        0, 1'b0, 64};
    vecs[8] = '{OP_WRITE, 6'h3F, 6'd1,  32'h11110000, 0, 1'b0, 2};
    vecs[9] = '{OP_READ,  6'h3E, 6'd3,  32'h0,        1, 1'b0, 4};

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    cur_op = OP_READ;
    rst = 1'b0; mem_clr = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_adr = '0; cmd_len = '0; cmd_data = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    // reset state and release
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    chk("reset_ctrl", {cmd_ready, wr_ready, rd_valid, done, err, ram_cs, ram_we}, 0);
    chk("reset_ram_adr", ram_adr, 0);
    chk("reset_ram_din", ram_din, 0);
    chk("reset_rd_data", rd_data, 0);
    rst = 1'b1;
    #1 chk("cmd_ready_before_edge", cmd_ready, 0);
    @(posedge clk); #1 chk("cmd_ready_first_edge", cmd_ready, 1);
    @(negedge clk);

    // single-word write timing
    send_cmd(OP_WRITE, 6'h05, 6'd0, 32'h0);
    wr_valid = 1'b1; wr_data = 32'h12345678;
    #1;
    chk("w1_cs_we", {ram_cs, ram_we}, 2'b11);
    chk("w1_adr", ram_adr, 6'h05);
    chk("w1_din", ram_din, 32'h12345678);
    ref_mem[5] = 32'h12345678;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("w1_done", {done, err, ram_cs}, 3'b100);
    @(negedge clk);
    chk("w1_idle", {done, cmd_ready}, 2'b01);

    // single-word read latency
    exp_q.push_back(32'h12345678);
    send_cmd(OP_READ, 6'h05, 6'd0, 32'h0);
    rd_ready = 1'b1;
    chk("r1_valid_c1", rd_valid, 0);
    @(negedge clk);
    chk("r1_valid_c2", rd_valid, 0);
    @(negedge clk);
    chk("r1_valid_c3", rd_valid, 1);
    if (rd_valid) pop_chk();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 10);
    rd_ready = 1'b0;
    chk("r1_done", done, 1);
    @(negedge clk);
    chk("r1_done_low", done, 0);

    // fill across the wrap point on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      a = 6'h3E + 6'(i);
      ref_mem[a] = 32'hA5A5A5A5;
    end
    send_cmd(OP_FILL, 6'h3E, 6'd3, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      a = 6'h3E + 6'(i);
      chk("fill_cs_we", {ram_cs, ram_we}, 2'b11);
      chk("fill_adr", ram_adr, a);
      chk("fill_din", ram_din, 32'hA5A5A5A5);
      @(negedge clk);
    end
    chk("fill_done", {done, ram_cs}, 2'b10);
    @(negedge clk);

    // reserved op
    acc0 = acc_cnt;
    send_cmd(OP_RESV, 6'h00, 6'd0, 32'h0);
    chk("resv_done_err", {done, err, ram_cs}, 3'b110);
    @(negedge clk);
    chk("resv_after", {done, err, cmd_ready}, 3'b001);
    chk("resv_no_access", acc_cnt - acc0, 0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // reset in the middle of an 8-word write
    run_vec('{OP_FILL, 6'h20, 6'd7, 32'h0, 0, 1'b0, 8});
    send_cmd(OP_WRITE, 6'h20, 6'd7, 32'h0);
    idx = 0; k = 0;
    while (idx < 3 && k < 20) begin
      wr_valid = 1'b1;
      wr_data  = 32'hBEEF0000 + 32'(idx);
      if (wr_ready) begin
        a = 6'h20 + 6'(idx);
        ref_mem[a] = wr_data;
        idx++;
      end
      @(negedge clk);
      k++;
    end
    chk("mid_words_before_reset", idx, 3);
    acc0 = acc_cnt; done0 = done_cnt;
    #1 rst = 1'b0;
    #1;
    chk("mid_reset_ctrl", {cmd_ready, wr_ready, rd_valid, done, err, ram_cs, ram_we}, 0);
    chk("mid_reset_adr_din", {ram_adr, ram_din}, 0);
    chk("mid_reset_rd_data", rd_data, 0);
    repeat (3) @(negedge clk);
    wr_valid = 1'b0;
    rst = 1'b1;
    #1 chk("mid_cmd_ready_before_edge", cmd_ready, 0);
    @(posedge clk); #1 chk("mid_cmd_ready_first_edge", cmd_ready, 1);
    @(negedge clk);
    chk("mid_no_access", acc_cnt - acc0, 0);
    chk("mid_no_done", done_cnt - done0, 0);
    run_vec('{OP_READ, 6'h20, 6'd7, 32'h0, 0, 1'b0, 8});

    chk("rw_direction_violations", viol, 0);
    chk("read_occupancy_le2", rd_max <= 2, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
